// File: rtl/error_blink_pkg.sv
// rtl/error_blink_pkg.sv - shared widths, sequencer state encoding and first-error helper
package error_blink_pkg;

    localparam int CNT_W   = 26;
    localparam int CODE_W  = 3;
    localparam int NUM_SRC = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } blink_state_t;

    // Lowest asserted source wins; returns source index + 1, or 0 when none.
    function automatic logic [CODE_W-1:0] first_code(input logic [NUM_SRC-1:0] src);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src[i]) begin
                code = CODE_W'(i + 1);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/error_blink_sequencer.sv
// rtl/error_blink_sequencer.sv - blink_sequencer: repeats err_code as LED pulses followed by a dark gap
module blink_sequencer
    import error_blink_pkg::*;
#(
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int GAP_CYCLES   = 50_000_000
) (
    input  logic              osc_50,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] code,
    input  logic              clear,
    output logic              led
);

    // Counter reloads with N-1 so each phase lasts exactly N cycles down to zero.
    localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    blink_state_t      state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [CODE_W-1:0] rem, rem_d;
    logic              led_d;

    always_ff @(posedge osc_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rem   <= '0;
            led   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            rem   <= rem_d;
            led   <= led_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rem_d   = rem;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rem_d   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (code != '0) begin
                        state_d = ST_ON;
                        cnt_d   = BLINK_LOAD;
                        rem_d   = code;
                    end
                end
                ST_ON: begin
                    if (cnt == '0) begin
                        state_d = ST_OFF;
                        cnt_d   = BLINK_LOAD;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (cnt == '0) begin
                        if (rem > CODE_W'(1)) begin
                            state_d = ST_ON;
                            cnt_d   = BLINK_LOAD;
                            rem_d   = rem - CODE_W'(1);
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = GAP_LOAD;
                            rem_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        if (code != '0) begin
                            state_d = ST_ON;
                            cnt_d   = BLINK_LOAD;
                            rem_d   = code;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rem_d   = '0;
                end
            endcase
        end
        // Registering the decoded next state keeps led glitch-free.
        led_d = (state_d == ST_ON);
    end

endmodule

// File: rtl/error_blink.sv
// rtl/error_blink.sv - latches per-source errors, records the first error code and drives a blink-code LED
module error_blink
    import error_blink_pkg::*;
#(
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int GAP_CYCLES   = 50_000_000
) (
    input  logic               osc_50,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] err_src,
    input  logic               clear,
    output logic [NUM_SRC-1:0] err_sticky,
    output logic [CODE_W-1:0]  err_code,
    output logic               error,
    output logic               led
);

    logic [NUM_SRC-1:0] sticky_base;
    logic [NUM_SRC-1:0] sticky_next;
    logic [CODE_W-1:0]  code_next;

    // A source present in the clear cycle survives the clear.
    always_comb begin
        sticky_base = clear ? '0 : err_sticky;
        sticky_next = sticky_base | err_src;
        code_next   = clear ? '0 : err_code;
        if ((sticky_base == '0) && (err_src != '0)) begin
            code_next = first_code(err_src);
        end
    end

    always_ff @(posedge osc_50 or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= '0;
            err_code   <= '0;
            error      <= 1'b0;
        end else begin
            err_sticky <= sticky_next;
            err_code   <= code_next;
            error      <= |sticky_next;
        end
    end

    blink_sequencer #(
        .BLINK_CYCLES (BLINK_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) u_blink_sequencer (
        .osc_50  (osc_50),
        .reset_n (reset_n),
        .code    (err_code),
        .clear   (clear),
        .led     (led)
    );

endmodule
